// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - SPI receive endpoint: synchronises sclk/cs/mosi and deserialises LSB-first frames
module spi_slave_rx #(
  parameter int DATA_WIDTH  = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  done,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [2:0] {ARM, IDLE, SKIP, SHIFT, WAITCS} state_t;

  state_t                state;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                  sclk_q;
  logic                  cs_q;
  logic [SYNC_STAGES:0]  flush;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] shreg;

  logic                  s_sclk;
  logic                  s_cs;
  logic                  s_mosi;
  logic                  sclk_fall;
  logic                  cs_fall;
  logic                  settled;
  logic [DATA_WIDTH-1:0] shift_next;

  assign s_sclk     = sclk_sync[SYNC_STAGES-1];
  assign s_cs       = cs_sync[SYNC_STAGES-1];
  assign s_mosi     = mosi_sync[SYNC_STAGES-1];
  assign sclk_fall  = sclk_q & ~s_sclk;
  assign cs_fall    = cs_q & ~s_cs;
  assign settled    = flush[SYNC_STAGES];
  assign shift_next = {s_mosi, shreg[DATA_WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      flush     <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sclk_q    <= s_sclk;
      cs_q      <= s_cs;
      flush     <= {flush[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // ARM waits for the cs chain to flush its reset value so a frame in flight at reset release is ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ARM;
      dout      <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      cnt       <= '0;
      shreg     <= '0;
    end else begin
      done      <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ARM: begin
          busy <= 1'b0;
          if (settled && s_cs) state <= IDLE;
        end
        IDLE: begin
          busy <= 1'b0;
          if (cs_fall) begin
            cnt   <= '0;
            shreg <= '0;
            state <= SKIP;
            busy  <= 1'b1;
          end
        end
        SKIP: begin
          if (s_cs) begin
            frame_err <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end else if (sclk_fall) begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // a final data edge coinciding with cs release still completes the frame
          if (sclk_fall) begin
            shreg <= shift_next;
            cnt   <= cnt + 1'b1;
            if (cnt == CW'(DATA_WIDTH - 1)) begin
              dout  <= shift_next;
              done  <= 1'b1;
              state <= WAITCS;
              busy  <= 1'b0;
            end
          end else if (s_cs) begin
            frame_err <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        WAITCS: begin
          busy <= 1'b0;
          if (s_cs) state <= IDLE;
        end
        default: begin
          state <= ARM;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
